reorder_buffer: RTL and testbench

In-order commit buffer for the out-of-order core. It sits between dispatch/rename (upstream) and the register-file write port consumed by RegRead and RetireCommit (downstream). It allocates one entry per cycle in program order and accepts one out-of-order completion per cycle. It retires one completed head entry per cycle to the architectural register file. A mispredicted branch, when it retires, flushes all younger entries.

---
 rtl/ooo_pkg.sv | 24 ++
 rtl/rob_entry_storage.sv | 57 +++++
 rtl/reorder_buffer.sv | 116 +++++++++++
 tb/tb_reorder_buffer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ooo_pkg.sv
// Shared out-of-order core types.
// Reorder buffer geometry and entry layout.
package ooo_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int TAG_W     = $clog2(ROB_DEPTH);

  typedef logic [TAG_W-1:0] rob_tag_t;
  typedef logic [TAG_W:0]   rob_cnt_t;

  localparam rob_cnt_t ROB_FULL = rob_cnt_t'(ROB_DEPTH);

  typedef struct packed {
    logic        valid;
    logic        done;
    logic        mispredict;
    logic        regwrite;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic [31:0] data;
    logic [31:0] altpc;
  } rob_entry_t;

endpackage

// File: rtl/rob_entry_storage.sv
// Reorder buffer entry array.
// Alloc write, completion write, head read, global clear.
module rob_entry_storage
  import ooo_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        alloc_en,
  input  rob_tag_t    alloc_tag,
  input  logic        alloc_regwrite,
  input  logic [4:0]  alloc_dest,
  input  logic [31:0] alloc_pc,
  input  logic        cmpl_en,
  input  rob_tag_t    cmpl_tag,
  input  logic [31:0] cmpl_data,
  input  logic        cmpl_mispredict,
  input  logic [31:0] cmpl_altpc,
  input  logic        retire_en,
  input  rob_tag_t    head_tag,
  input  logic        clear_all,
  output rob_entry_t  head_entry
);

  rob_entry_t mem [ROB_DEPTH];

  // Entry updates; valid clears are applied last so they win.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        if (cmpl_en && cmpl_tag == rob_tag_t'(i) && mem[i].valid) begin
          mem[i].done       <= 1'b1;
          mem[i].data       <= cmpl_data;
          mem[i].mispredict <= cmpl_mispredict;
          mem[i].altpc      <= cmpl_altpc;
        end
        if (alloc_en && alloc_tag == rob_tag_t'(i)) begin
          mem[i].valid      <= 1'b1;
          mem[i].done       <= 1'b0;
          mem[i].mispredict <= 1'b0;
          mem[i].regwrite   <= alloc_regwrite;
          mem[i].dest       <= alloc_dest;
          mem[i].pc         <= alloc_pc;
        end
        if (clear_all || (retire_en && head_tag == rob_tag_t'(i))) begin
          mem[i].valid <= 1'b0;
        end
      end
    end
  end

  assign head_entry = mem[head_tag];

endmodule

// File: rtl/reorder_buffer.sv
// In-order commit buffer.
// Allocates in order, completes out of order, retires in order.
module reorder_buffer
  import ooo_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Alloc_Valid,
  input  logic             Alloc_RegWrite,
  input  logic [4:0]       Alloc_DestReg,
  input  logic [31:0]      Alloc_PC,
  output logic             Alloc_Ready,
  output logic [TAG_W-1:0] Alloc_Tag,
  input  logic             Complete_Valid,
  input  logic [TAG_W-1:0] Complete_Tag,
  input  logic [31:0]      Complete_Data,
  input  logic             Complete_Mispredict,
  input  logic [31:0]      Complete_AltPC,
  output logic             Retire_Valid,
  output logic             Retire_RegWrite,
  output logic [4:0]       Retire_Reg,
  output logic [31:0]      Retire_Data,
  output logic [31:0]      Retire_PC,
  output logic             Flush_Valid,
  output logic [31:0]      Flush_PC,
  output logic             Empty,
  output logic [TAG_W:0]   Count
);

  rob_tag_t   head;
  rob_tag_t   tail;
  rob_entry_t head_e;
  logic       retire_now;
  logic       flush_now;
  logic       alloc_fire;
  logic       cmpl_en;

  assign retire_now  = head_e.valid && head_e.done;
  assign flush_now   = retire_now && head_e.mispredict;
  assign Alloc_Ready = (Count != ROB_FULL) && !flush_now;
  assign alloc_fire  = Alloc_Valid && Alloc_Ready;
  assign cmpl_en     = Complete_Valid && !flush_now;
  assign Alloc_Tag   = tail;
  assign Empty       = (Count == '0);

  rob_entry_storage u_store (
    .clk             (CLK),
    .rst             (RESET),
    .alloc_en        (alloc_fire),
    .alloc_tag       (tail),
    .alloc_regwrite  (Alloc_RegWrite),
    .alloc_dest      (Alloc_DestReg),
    .alloc_pc        (Alloc_PC),
    .cmpl_en         (cmpl_en),
    .cmpl_tag        (Complete_Tag),
    .cmpl_data       (Complete_Data),
    .cmpl_mispredict (Complete_Mispredict),
    .cmpl_altpc      (Complete_AltPC),
    .retire_en       (retire_now),
    .head_tag        (head),
    .clear_all       (flush_now),
    .head_entry      (head_e)
  );

  // Head/tail pointers and occupancy; flush restarts at head+1.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      head  <= '0;
      tail  <= '0;
      Count <= '0;
    end else begin
      if (retire_now) begin
        head <= head + 1'b1;
      end
      if (flush_now) begin
        tail  <= head + 1'b1;
        Count <= '0;
      end else begin
        if (alloc_fire) begin
          tail <= tail + 1'b1;
        end
        if (alloc_fire && !retire_now) begin
          Count <= Count + 1'b1;
        end else if (!alloc_fire && retire_now) begin
          Count <= Count - 1'b1;
        end
      end
    end
  end

  // Registered retire and redirect outputs; fields hold between pulses.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      Retire_Valid    <= 1'b0;
      Retire_RegWrite <= 1'b0;
      Retire_Reg      <= '0;
      Retire_Data     <= '0;
      Retire_PC       <= '0;
      Flush_Valid     <= 1'b0;
      Flush_PC        <= '0;
    end else begin
      Retire_Valid <= retire_now;
      Flush_Valid  <= flush_now;
      if (retire_now) begin
        Retire_RegWrite <= head_e.regwrite;
        Retire_Reg      <= head_e.dest;
        Retire_Data     <= head_e.data;
        Retire_PC       <= head_e.pc;
      end
      if (flush_now) begin
        Flush_PC <= head_e.altpc;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer.
// Vector table plus directed multi-cycle sequences.
module tb_reorder_buffer;
  import ooo_pkg::*;

  logic             CLK;
  logic             RESET;
  logic             Alloc_Valid;
  logic             Alloc_RegWrite;
  logic [4:0]       Alloc_DestReg;
  logic [31:0]      Alloc_PC;
  logic             Alloc_Ready;
  logic [TAG_W-1:0] Alloc_Tag;
  logic             Complete_Valid;
  logic [TAG_W-1:0] Complete_Tag;
  logic [31:0]      Complete_Data;
  logic             Complete_Mispredict;
  logic [31:0]      Complete_AltPC;
  logic             Retire_Valid;
  logic             Retire_RegWrite;
  logic [4:0]       Retire_Reg;
  logic [31:0]      Retire_Data;
  logic [31:0]      Retire_PC;
  logic             Flush_Valid;
  logic [31:0]      Flush_PC;
  logic             Empty;
  logic [TAG_W:0]   Count;

  reorder_buffer dut (
    .CLK                 (CLK),
    .RESET               (RESET),
    .Alloc_Valid         (Alloc_Valid),
    .Alloc_RegWrite      (Alloc_RegWrite),
    .Alloc_DestReg       (Alloc_DestReg),
    .Alloc_PC            (Alloc_PC),
    .Alloc_Ready         (Alloc_Ready),
    .Alloc_Tag           (Alloc_Tag),
    .Complete_Valid      (Complete_Valid),
    .Complete_Tag        (Complete_Tag),
    .Complete_Data       (Complete_Data),
    .Complete_Mispredict (Complete_Mispredict),
    .Complete_AltPC      (Complete_AltPC),
    .Retire_Valid        (Retire_Valid),
    .Retire_RegWrite     (Retire_RegWrite),
    .Retire_Reg          (Retire_Reg),
    .Retire_Data         (Retire_Data),
    .Retire_PC           (Retire_PC),
    .Flush_Valid         (Flush_Valid),
    .Flush_PC            (Flush_PC),
    .Empty               (Empty),
    .Count               (Count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    Alloc_Valid         = 1'b0;
    Alloc_RegWrite      = 1'b0;
    Alloc_DestReg       = '0;
    Alloc_PC            = '0;
    Complete_Valid      = 1'b0;
    Complete_Tag        = '0;
    Complete_Data       = '0;
    Complete_Mispredict = 1'b0;
    Complete_AltPC      = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk("rst_count", 32'(Count), 0);
    chk("rst_empty", 32'(Empty), 1);
    chk("rst_rv", 32'(Retire_Valid), 0);
    chk("rst_fv", 32'(Flush_Valid), 0);
    chk("rst_rdata", Retire_Data, 0);
    chk("rst_fpc", Flush_PC, 0);
    chk("rst_ready", 32'(Alloc_Ready), 1);
    chk("rst_tag", 32'(Alloc_Tag), 0);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  typedef struct {
    int av;
    int dest;
    int cv;
    int ctag;
    int cdata;
    int rdy;
    int atag;
    int rv;
    int rreg;
    int rdata;
    int cnt;
  } vec_t;

  vec_t v [11];

  int n_alloc;
  int n_ret;
  int pend [$];
  int t;
  int rv_seen;
  int fv_seen;
  logic fired;
  logic cmpl;

  initial begin
    RESET = 1'b0;
    idle_inputs();

    //        av dst cv tag data     rdy atg rv reg data cnt
    v[0]  = '{1, 5,  0, 0, 0,        1,  0,  0, 0, 0,   1};
    v[1]  = '{1, 6,  0, 0, 0,        1,  1,  0, 0, 0,   2};
    v[2]  = '{1, 7,  0, 0, 0,        1,  2,  0, 0, 0,   3};
    v[3]  = '{0, 0,  1, 2, 'hA,      1,  3,  0, 0, 0,   3};
    v[4]  = '{0, 0,  1, 0, 'hB,      1,  3,  0, 0, 0,   3};
    v[5]  = '{0, 0,  1, 1, 'hC,      1,  3,  1, 5, 'hB, 2};
    v[6]  = '{0, 0,  0, 0, 0,        1,  3,  1, 6, 'hC, 1};
    v[7]  = '{0, 0,  0, 0, 0,        1,  3,  1, 7, 'hA, 0};
    v[8]  = '{0, 0,  0, 0, 0,        1,  3,  0, 7, 'hA, 0};
    v[9]  = '{0, 0,  1, 9, 'hDEAD,   1,  3,  0, 7, 'hA, 0};
    v[10] = '{0, 0,  1, 1, 'h55,     1,  3,  0, 7, 'hA, 0};

    // Out-of-order completion, in-order retire, stray completions.
    do_reset();
    @(posedge CLK);
    #1;
    for (int i = 0; i < 11; i++) begin
      Alloc_Valid    = v[i].av[0];
      Alloc_RegWrite = 1'b1;
      Alloc_DestReg  = v[i].dest[4:0];
      Alloc_PC       = 32'h100 + 32'(i * 4);
      Complete_Valid = v[i].cv[0];
      Complete_Tag   = v[i].ctag[3:0];
      Complete_Data  = v[i].cdata;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(Alloc_Ready), v[i].rdy);
      chk($sformatf("v%0d_atag", i), 32'(Alloc_Tag), v[i].atag);
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d_rv", i), 32'(Retire_Valid), v[i].rv);
      chk($sformatf("v%0d_rreg", i), 32'(Retire_Reg), v[i].rreg);
      chk($sformatf("v%0d_rdata", i), Retire_Data, v[i].rdata);
      chk($sformatf("v%0d_cnt", i), 32'(Count), v[i].cnt);
      chk($sformatf("v%0d_empty", i), 32'(Empty),
          (v[i].cnt == 0) ? 1 : 0);
    end
    idle_inputs();

    // Fill to full, refuse a 17th, refuse while head retires at full.
    do_reset();
    @(posedge CLK);
    #1;
    for (int i = 0; i < 16; i++) begin
      Alloc_Valid   = 1'b1;
      Alloc_DestReg = 5'(i);
      #1;
      chk($sformatf("full_tag%0d", i), 32'(Alloc_Tag), i);
      @(posedge CLK);
      #1;
    end
    chk("full_cnt", 32'(Count), 16);
    chk("full_ready", 32'(Alloc_Ready), 0);
    chk("full_tagwrap", 32'(Alloc_Tag), 0);
    @(posedge CLK);
    #1;
    chk("full_17th_cnt", 32'(Count), 16);
    Complete_Valid = 1'b1;
    Complete_Tag   = '0;
    Complete_Data  = 32'h1234;
    @(posedge CLK);
    #1;
    Complete_Valid = 1'b0;
    chk("full_ret_ready", 32'(Alloc_Ready), 0);
    @(posedge CLK);
    #1;
    chk("full_ret_rv", 32'(Retire_Valid), 1);
    chk("full_ret_cnt", 32'(Count), 15);
    chk("full_after_ready", 32'(Alloc_Ready), 1);
    chk("full_after_tag", 32'(Alloc_Tag), 0);
    @(posedge CLK);
    #1;
    chk("full_refill_cnt", 32'(Count), 16);
    idle_inputs();

    // Mispredicted branch at tag 1 flushes tags 2 and 3.
    do_reset();
    @(posedge CLK);
    #1;
    for (int i = 0; i < 4; i++) begin
      Alloc_Valid    = 1'b1;
      Alloc_RegWrite = 1'b1;
      Alloc_DestReg  = 5'(10 + i);
      Alloc_PC       = 32'h400000 + 32'(4 * i);
      @(posedge CLK);
      #1;
    end
    Alloc_Valid         = 1'b0;
    Complete_Valid      = 1'b1;
    Complete_Tag        = 4'd1;
    Complete_Data       = 32'h11;
    Complete_Mispredict = 1'b1;
    Complete_AltPC      = 32'h400100;
    @(posedge CLK);
    #1;
    Complete_Tag        = 4'd0;
    Complete_Data       = 32'h77;
    Complete_Mispredict = 1'b0;
    Complete_AltPC      = '0;
    @(posedge CLK);
    #1;
    Complete_Valid = 1'b0;
    chk("fl_pre_ready", 32'(Alloc_Ready), 1);
    @(posedge CLK);
    #1;
    chk("fl_t0_rv", 32'(Retire_Valid), 1);
    chk("fl_t0_reg", 32'(Retire_Reg), 10);
    chk("fl_t0_data", Retire_Data, 32'h77);
    chk("fl_t0_fv", 32'(Flush_Valid), 0);
    chk("fl_t0_cnt", 32'(Count), 3);
    Complete_Valid = 1'b1;
    Complete_Tag   = 4'd2;
    Complete_Data  = 32'h99;
    Alloc_Valid    = 1'b1;
    Alloc_DestReg  = 5'd20;
    #1;
    chk("fl_ready", 32'(Alloc_Ready), 0);
    @(posedge CLK);
    #1;
    idle_inputs();
    chk("fl_t1_rv", 32'(Retire_Valid), 1);
    chk("fl_t1_reg", 32'(Retire_Reg), 11);
    chk("fl_t1_pc", Retire_PC, 32'h400004);
    chk("fl_fv", 32'(Flush_Valid), 1);
    chk("fl_fpc", Flush_PC, 32'h400100);
    chk("fl_cnt", 32'(Count), 0);
    chk("fl_empty", 32'(Empty), 1);
    chk("fl_newtail", 32'(Alloc_Tag), 2);
    rv_seen = 0;
    fv_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK);
      #1;
      if (Retire_Valid) rv_seen++;
      if (Flush_Valid) fv_seen++;
    end
    chk("fl_no_more_rv", 32'(rv_seen), 0);
    chk("fl_fv_pulse", 32'(fv_seen), 0);
    chk("fl_cnt_stay", 32'(Count), 0);

    // 40-transaction stream with slow completion; wraps and fills.
    do_reset();
    @(posedge CLK);
    #1;
    n_alloc = 0;
    n_ret   = 0;
    pend.delete();
    for (int cyc = 0; cyc < 400 && n_ret < 40; cyc++) begin
      idle_inputs();
      Alloc_Valid    = (n_alloc < 40);
      Alloc_RegWrite = n_alloc[0];
      Alloc_DestReg  = n_alloc[4:0];
      Alloc_PC       = 32'h2000 + 32'(n_alloc * 4);
      if (pend.size() > 0 && (cyc % 2) == 0) begin
        t = pend[0];
        Complete_Valid = 1'b1;
        Complete_Tag   = t[3:0];
        Complete_Data  = 32'h1000 + 32'(t);
      end
      #1;
      if (Alloc_Valid) begin
        chk("st_atag", 32'(Alloc_Tag), n_alloc % 16);
      end
      fired = Alloc_Valid && Alloc_Ready;
      cmpl  = Complete_Valid;
      @(posedge CLK);
      #1;
      if (fired) begin
        pend.push_back(n_alloc);
        n_alloc++;
      end
      if (cmpl) void'(pend.pop_front());
      if (Retire_Valid) begin
        chk("st_rreg", 32'(Retire_Reg), n_ret % 32);
        chk("st_rdata", Retire_Data, 32'h1000 + 32'(n_ret));
        chk("st_rwe", 32'(Retire_RegWrite), n_ret % 2);
        n_ret++;
      end
      chk("st_cnt", 32'(Count), n_alloc - n_ret);
    end
    chk("st_retired", 32'(n_ret), 40);
    idle_inputs();

    // Asynchronous reset mid-cycle with 5 entries and a live retire.
    do_reset();
    @(posedge CLK);
    #1;
    for (int i = 0; i < 5; i++) begin
      Alloc_Valid   = 1'b1;
      Alloc_DestReg = 5'(i + 1);
      @(posedge CLK);
      #1;
    end
    Alloc_Valid    = 1'b0;
    Complete_Valid = 1'b1;
    Complete_Tag   = '0;
    Complete_Data  = 32'h5A5A;
    @(posedge CLK);
    #1;
    Complete_Valid = 1'b0;
    @(posedge CLK);
    #1;
    chk("ar_pre_rv", 32'(Retire_Valid), 1);
    chk("ar_pre_cnt", 32'(Count), 4);
    #1;
    RESET = 1'b1;
    #1;
    chk("ar_cnt", 32'(Count), 0);
    chk("ar_empty", 32'(Empty), 1);
    chk("ar_rv", 32'(Retire_Valid), 0);
    chk("ar_tag", 32'(Alloc_Tag), 0);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    chk("ar_post_rv", 32'(Retire_Valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
